apb_req_arbiter: RTL

Round-robin arbiter and transfer sequencer that shares the single request port of the `apb_bridge` between `NUM_REQ` independent requesters. It accepts one request at a time and decodes the target slave from the top two address bits. It drives `data`/`addr`/`write`/`enable`/`sel1..sel4` into the bridge, holds them stable until `PREADY`, then returns `PRDATA`/`PSLVERR` to the granted requester. An optional watchdog aborts transfers that never complete.

---
 rtl/apb_req_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Shares the single request port of apb_bridge between NUM_REQ requesters.
// Round-robin grant from a rotating pointer, one transfer in flight at a time.
// The target slave is decoded from the top two address bits into sel1..sel4.
// Bridge-side outputs are held stable from grant until PREADY. The response
// (PRDATA/PSLVERR) is then returned to the granted requester as a one-cycle
// pulse. Every output is registered.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a transfer that has not seen PREADY by its
//   TIMEOUT_CYC-th enable cycle. The abort returns rsp_err=1 and rsp_rdata=0.
//
// Ports
//   PCLK, PRESETn      clock, synchronous active-low reset
//   req_valid/_write   per-requester request and direction (1 = write)
//   req_addr/_wdata    packed per-requester payload, requester i at [i*W +: W]
//   req_ready          one-hot, one-cycle accept pulse
//   rsp_valid          one-hot, one-cycle completion pulse
//   rsp_rdata/_err     response payload, held until the next completion
//   data/addr/write    to bridge
//   enable, sel1..4    to bridge
//   PRDATA/PREADY/PSLVERR  from bridge
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         data,
  output logic [ADDR_W-1:0]         addr,
  output logic                      write,
  output logic                      enable,
  output logic                      sel1,
  output logic                      sel2,
  output logic                      sel3,
  output logic                      sel4,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic                enable_q;
  logic [3:0]          sel_q;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  // Counts completed enable cycles of the current transfer; equals
  // TIMEOUT_CYC-1 during the last enable cycle allowed.
  logic [CNT_W-1:0]    cnt_q;
`endif

  // Winner of the round-robin search and its payload.
  logic                hit_d;
  logic [IDX_W-1:0]    win_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_wdata_d;
  logic                win_write_d;
  logic [3:0]          win_sel_d;
  logic [IDX_W-1:0]    ptr_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int j;
    hit_d       = 1'b0;
    win_d       = '0;
    j           = 0;
    // First requesting index found searching upward from ptr_q, wrapping.
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!hit_d && req_valid[j]) begin
        hit_d = 1'b1;
        win_d = IDX_W'(j);
      end
    end
    win_addr_d  = req_addr[int'(win_d)*ADDR_W +: ADDR_W];
    win_wdata_d = req_wdata[int'(win_d)*DATA_W +: DATA_W];
    win_write_d = req_write[win_d];
    case (win_addr_d[ADDR_W-1 -: 2])
      2'b00:   win_sel_d = 4'b0001;
      2'b01:   win_sel_d = 4'b0010;
      2'b10:   win_sel_d = 4'b0100;
      default: win_sel_d = 4'b1000;
    endcase
    // Pointer after a completion: one past the granted requester, wrapping.
    ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      enable_q    <= 1'b0;
      sel_q       <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      // Both pulses last exactly one cycle unless set again below.
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (hit_d) begin
            gnt_q              <= win_d;
            addr_q             <= win_addr_d;
            data_q             <= win_wdata_d;
            write_q            <= win_write_d;
            sel_q              <= win_sel_d;
            enable_q           <= 1'b1;
            req_ready_q[win_d] <= 1'b1;
            state_q            <= ST_XFER;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q              <= '0;
`endif
          end
        end
        ST_XFER: begin
          if (PREADY) begin
            enable_q           <= 1'b0;
            sel_q              <= '0;
            rsp_valid_q[gnt_q] <= 1'b1;
            rsp_rdata_q        <= write_q ? '0 : PRDATA;
            rsp_err_q          <= PSLVERR;
            ptr_q              <= ptr_d;
            state_q            <= ST_IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            // Watchdog abort; a late PREADY then lands in IDLE and is ignored.
            enable_q           <= 1'b0;
            sel_q              <= '0;
            rsp_valid_q[gnt_q] <= 1'b1;
            rsp_rdata_q        <= '0;
            rsp_err_q          <= 1'b1;
            ptr_q              <= ptr_d;
            state_q            <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign data      = data_q;
  assign addr      = addr_q;
  assign write     = write_q;
  assign enable    = enable_q;
  assign sel1      = sel_q[0];
  assign sel2      = sel_q[1];
  assign sel3      = sel_q[2];
  assign sel4      = sel_q[3];

endmodule
